// File: rtl/onehot_req_arbiter.sv
// onehot_req_arbiter: round-robin arbiter presenting one sticky request at a time as a registered one-hot grant
module onehot_req_arbiter #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [7:0] pending,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;
    state_t     state, nxt;
    logic [2:0] ptr, gidx, sel, idx;
    logic [3:0] cnt;
    logic       found, take;
    logic [7:0] clr;

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign take = (state == OFFER) && ack;
    assign clr  = take ? 8'b1 << gidx : 8'b0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = found ? OFFER : IDLE;
            OFFER:   nxt = ack ? (GAP_CYCLES > 0 ? GAP : IDLE) : OFFER;
            GAP:     nxt = (cnt == 4'd0) ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            pending   <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
        end else begin
            state   <= nxt;
            busy    <= nxt != IDLE;
            pending <= (pending & ~clr) | req;
            if (state == IDLE && found) begin
                gnt       <= 8'b1 << sel;
                gnt_valid <= 1'b1;
                gidx      <= sel;
            end
            if (take) begin
                gnt       <= '0;
                gnt_valid <= 1'b0;
                ptr       <= gidx + 3'd1;
                cnt       <= 4'(GAP_CYCLES - 1);
            end
            if (state == GAP && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_onehot_req_arbiter.sv
// tb_onehot_req_arbiter: directed checks of grant order, hold, gap timing, set-wins and async reset
module tb_onehot_req_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req0 = '0, req1 = '0;
    logic       ack0 = 1'b0, ack1 = 1'b0;
    logic [7:0] gnt0, gnt1, pend0, pend1;
    logic       gv0, gv1, busy0, busy1;
    int         passed = 0, total = 0;

    onehot_req_arbiter #(.GAP_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .ack(ack0),
        .gnt(gnt0), .gnt_valid(gv0), .pending(pend0), .busy(busy0)
    );
    onehot_req_arbiter #(.GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1),
        .gnt(gnt1), .gnt_valid(gv1), .pending(pend1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_gnt", gnt0, 0);
        chk("rst_gv", gv0, 0);
        chk("rst_pend", pend0, 0);
        chk("rst_busy", busy0, 0);
        rst_n = 1'b1;
        tick();
        // single request
        req0 = 8'h08; tick(); req0 = 0;
        chk("single_pend", pend0, 8'h08);
        chk("single_gv_early", gv0, 0);
        tick();
        chk("single_gnt", gnt0, 8'h08);
        chk("single_gv", gv0, 1);
        chk("single_busy", busy0, 1);
        ack0 = 1; tick(); ack0 = 0;
        chk("single_gap_gnt", gnt0, 0);
        chk("single_gap_gv", gv0, 0);
        chk("single_gap_pend", pend0, 0);
        chk("single_gap_busy", busy0, 1);
        tick();
        chk("single_idle_busy", busy0, 0);
        // serve index 5 then wrap to 7 before 1
        req0 = 8'h20; tick(); req0 = 0; tick();
        chk("idx5_gnt", gnt0, 8'h20);
        ack0 = 1; tick(); ack0 = 0; tick();
        req0 = 8'h82; tick(); req0 = 0; tick();
        chk("wrap_first", gnt0, 8'h80);
        ack0 = 1; tick(); ack0 = 0; tick(); tick();
        chk("wrap_second", gnt0, 8'h02);
        ack0 = 1; tick(); ack0 = 0; tick();
        // hold under new requests
        req0 = 8'h10; tick(); req0 = 0; tick();
        chk("hold_gnt0", gnt0, 8'h10);
        for (int i = 0; i < 20; i++) begin
            req0 = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            chk("hold_gnt", gnt0, 8'h10);
        end
        req0 = 0;
        chk("hold_pend", pend0, 8'h11);
        ack0 = 1; tick(); ack0 = 0;
        chk("hold_pend_after", pend0, 8'h01);
        tick(); tick();
        chk("hold_next", gnt0, 8'h01);
        ack0 = 1; tick(); ack0 = 0; tick();
        // set wins over clear
        req0 = 8'h04; tick(); req0 = 0; tick();
        chk("sw_gnt", gnt0, 8'h04);
        ack0 = 1; req0 = 8'h04; tick(); ack0 = 0; req0 = 0;
        chk("sw_pend", pend0, 8'h04);
        chk("sw_gv", gv0, 0);
        tick(); tick();
        chk("sw_regrant", gnt0, 8'h04);
        ack0 = 1; tick(); ack0 = 0; tick();
        // asynchronous reset mid-offer
        req0 = 8'h40; tick(); req0 = 0; tick();
        chk("ro_gnt", gnt0, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("ro_gnt0", gnt0, 0);
        chk("ro_gv", gv0, 0);
        chk("ro_pend", pend0, 0);
        chk("ro_busy", busy0, 0);
        #2 rst_n = 1'b1;
        req0 = 8'h01; tick(); req0 = 0; tick();
        chk("ro_first", gnt0, 8'h01);
        ack0 = 1; tick(); ack0 = 0;
        // full sweep, GAP_CYCLES = 0, ack tied high
        ack1 = 1; req1 = 8'hFF; tick(); req1 = 0;
        chk("sweep_pend", pend1, 8'hFF);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("sweep_gnt", gnt1, 32'h1 << j);
            chk("sweep_gv", gv1, 1);
            tick();
            chk("sweep_gap", gv1, 0);
        end
        chk("sweep_pend_end", pend1, 0);
        ack1 = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
